// File: rtl/binary_to_gray_counter.sv
// Registered binary up-counter with a matching registered Gray output and a wrap pulse.
// Optional macro GRAY_CNT_SATURATE_EN: an increment at all-ones holds at max instead of wrapping.
module binary_to_gray_counter #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [DSIZE-1:0] load_value,
  input  logic             inc,
  output logic [DSIZE-1:0] binary_value,
  output logic [DSIZE-1:0] gray_value,
  output logic             wrap
);

  localparam logic [DSIZE-1:0] MAX_VAL = {DSIZE{1'b1}};
  localparam logic [DSIZE-1:0] ONE_VAL = {{(DSIZE-1){1'b0}}, 1'b1};

  function automatic logic [DSIZE-1:0] bin_to_gray(input logic [DSIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [DSIZE-1:0] bin_d, bin_q;
  logic [DSIZE-1:0] gray_d, gray_q;
  logic             wrap_d, wrap_q;

  // Next-state selection: clr over load over inc over hold; Gray derives from the next binary.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_value;
    end else if (inc) begin
      if (bin_q == MAX_VAL) begin
`ifdef GRAY_CNT_SATURATE_EN
        bin_d = bin_q;
`else
        bin_d = '0;
`endif
        wrap_d = 1'b1;
      end else begin
        bin_d = bin_q + ONE_VAL;
      end
    end else begin
      bin_d = bin_q;
    end
    gray_d = bin_to_gray(bin_d);
  end

  // Output registers; Gray comes straight from a flop so consumers never see glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign binary_value = bin_q;
  assign gray_value   = gray_q;
  assign wrap         = wrap_q;

endmodule

// File: doc/binary_to_gray_counter.md
Name: binary_to_gray_counter

Overview:
- Registered binary up-counter that also outputs the matching Gray code, with both outputs updated in the same cycle.
- Write-side counterpart of the Gray-to-binary decode: it produces glitch-free Gray values that another clock domain synchronises and then decodes.
- Typical use: read and write pointers of an asynchronous FIFO, and cross-domain event counters.
- The Gray output comes straight from a flop, so at most one bit changes per increment.

Parameters:
DSIZE, 8, width of the counter, binary_value and gray_value (legal range 2..32)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear to zero, highest priority
load  input  1  synchronous load of load_value
load_value  input  DSIZE  binary value to load
inc  input  1  increment by one this cycle
binary_value  output  DSIZE  registered binary count
gray_value  output  DSIZE  registered Gray code of binary_value
wrap  output  1  one-cycle pulse; the counter wrapped from all-ones to zero (or was held at max under the optional feature)

Behaviour:
- Reset: while rst_n is low, asynchronously force binary_value=0, gray_value=0, wrap=0. Release is synchronous to clk.
- Next-state priority, evaluated on each rising clk edge:
  - clr: next binary = 0.
  - else load: next binary = load_value.
  - else inc: next binary = binary_value + 1, modulo 2^DSIZE.
  - else: hold.
- Gray encoding is computed combinationally from the next binary value and registered: next_gray = next_bin ^ (next_bin >> 1).
  - gray_value therefore always equals the Gray code of binary_value in the same cycle. There is no extra latency between them.
- Latency: one clock from inc, load or clr to the updated outputs.
- Wrap:
  - wrap=1 for exactly one cycle after the edge where inc was accepted with binary_value = 2^DSIZE-1 and neither clr nor load was active.
  - In every other cycle wrap=0.
- Counting a sequence of increments changes exactly one bit of gray_value per step, including the wrap from all-ones to zero.
- load and clr may change several Gray bits at once. The user must only assert them while the consuming domain is quiescent or in reset.
- Simultaneous requests:
  - clr with load and/or inc: clr wins, wrap=0.
  - load with inc: the loaded value is used and inc is ignored.
- Holding inc high counts continuously, one step per cycle.
- No combinational path from any input to any output.

Optional Feature:
- Macro: GRAY_CNT_SATURATE_EN
- Defined:
  - inc at binary_value = 2^DSIZE-1 holds the counter at max; binary and Gray are unchanged.
  - wrap pulses for one cycle to flag the overflow attempt.
  - clr and load behave as normal.
- Not defined: modulo wrap-around as described in Behaviour. Wrap-around is the default.

Test Plan:
All cases use DSIZE=4.
1. Reset: assert rst_n=0 mid-count at binary=9 with no clock edge -> binary_value=0, gray_value=0 and wrap=0 immediately; outputs stay 0 after release until inc.
2. Count sequence: inc held for 16 cycles from 0 -> binary 1..15 then 0; gray follows 0001,0011,0010,0110,...,1000 then 0000. Each step differs from the previous Gray value by exactly one bit (check with popcount of the XOR). wrap=1 only in the cycle after 15->0.
3. Load: load=1, load_value=5, inc=1 -> next cycle binary=5, gray=0111, wrap=0. Then one inc -> binary=6, gray=0101.
4. Priority: clr=1, load=1, inc=1 at binary=15 -> binary=0, gray=0000, wrap=0.
5. Hold: inc=0, clr=0, load=0 for 10 cycles at binary=10 -> binary stays 10, gray stays 1111, wrap stays 0.
6. Saturate (with GRAY_CNT_SATURATE_EN defined): inc at binary=15 for 3 cycles -> binary=15 and gray=1000 throughout, wrap=1 each cycle. Then clr -> binary=0.
7. Round trip: feed gray_value into the team's Gray-to-binary converter on a random inc/load/clr stream -> decoded value equals binary_value every cycle.
